// File: rtl/ram_pkg.sv
// Shared constants for the RAM-style storage blocks and the FIFO built on them.
package ram_pkg;

    localparam int unsigned DATAWIDTH = 8;
    localparam int unsigned ADSWIDTH  = 4;

    // Occupancy counter must represent 0..depth inclusive, so one bit wider than a pointer.
    function automatic int unsigned count_width(input int unsigned adswidth);
        return adswidth + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_mem.sv
// Storage array for ram_fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ram_fifo_mem
    import ram_pkg::*;
#(
    parameter int unsigned datawidth = DATAWIDTH,
    parameter int unsigned adswidth  = ADSWIDTH,
    parameter int unsigned depth     = 1 << adswidth
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [adswidth-1:0]  wa,
    input  logic [datawidth-1:0] wd,
    input  logic [adswidth-1:0]  ra,
    output logic [datawidth-1:0] rd
);

    logic [datawidth-1:0] mem [depth];

    // Write port: store the word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/ram_fifo.sv
// Synchronous FIFO on top of ram_fifo_mem with occupancy count, full/empty
// status and sticky overflow/underflow flags.
// Define RAM_FIFO_FWFT_EN for a first-word-fall-through read port; otherwise
// the read data is registered with one cycle of pop latency.
module ram_fifo
    import ram_pkg::*;
#(
    parameter int unsigned datawidth = DATAWIDTH,
    parameter int unsigned adswidth  = ADSWIDTH,
    parameter int unsigned depth     = 1 << adswidth
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wen,
    input  logic                                  ren,
    input  logic [datawidth-1:0]                  in,
    output logic [datawidth-1:0]                  out,
    output logic                                  full,
    output logic                                  empty,
    output logic [count_width(adswidth)-1:0]      count,
    output logic                                  ovf,
    output logic                                  udf
);

    localparam int unsigned cw = count_width(adswidth);

    logic [adswidth-1:0]  wr_ptr;
    logic [adswidth-1:0]  rd_ptr;
    logic [datawidth-1:0] rd_data;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (count == cw'(depth));
    assign empty   = (count == '0);
    // A push into a full FIFO is still accepted when a pop frees the slot on the same edge.
    assign push_ok = wen & (~full | ren);
    assign pop_ok  = ren & ~empty;

    ram_fifo_mem #(
        .datawidth (datawidth),
        .adswidth  (adswidth),
        .depth     (depth)
    ) u_mem (
        .clk (clk),
        .we  (push_ok),
        .wa  (wr_ptr),
        .wd  (in),
        .ra  (rd_ptr),
        .rd  (rd_data)
    );

    // Pointers and occupancy; pointers wrap naturally at depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + adswidth'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + adswidth'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + cw'(1);
                2'b01:   count <= count - cw'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf | (wen & full & ~ren);
            udf <= udf | (ren & empty);
        end
    end

`ifdef RAM_FIFO_FWFT_EN
    assign out = rd_data;
`else
    // Registered read: capture the head word on each accepted pop, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else if (pop_ok) begin
            out <= rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo.sv
// Directed self-checking bench for ram_fifo (depth 16, 8-bit data).
module tb_ram_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wen;
    logic       ren;
    logic [7:0] din;
    logic [7:0] out;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       ovf;
    logic       udf;

    int checks = 0;
    int errors = 0;

    ram_fifo dut (
        .clk   (clk),
        .rst   (rst),
        .wen   (wen),
        .ren   (ren),
        .in    (din),
        .out   (out),
        .full  (full),
        .empty (empty),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request; inputs return idle 1 ns after the edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        wen = w;
        ren = r;
        din = d;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
        din = 8'h00;
    endtask

    // Pop (optionally with a simultaneous push) and check the popped word.
    task automatic pop_chk(input string tag, input logic [7:0] exp,
                           input logic w, input logic [7:0] d);
`ifdef RAM_FIFO_FWFT_EN
        chk(tag, 32'(out), 32'(exp));
        cycle(w, 1'b1, d);
`else
        cycle(w, 1'b1, d);
        chk(tag, 32'(out), 32'(exp));
`endif
    endtask

    initial begin
        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        din = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_ovf",   32'(ovf),   32'd0);
        chk("rst_udf",   32'(udf),   32'd0);
`ifndef RAM_FIFO_FWFT_EN
        chk("rst_out",   32'(out),   32'd0);
`endif
        rst = 1'b0;

        // Fill 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h10 + i));
            if (i == 0) begin
                chk("fill1_count", 32'(count), 32'd1);
                chk("fill1_empty", 32'(empty), 32'd0);
            end
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_ovf",   32'(ovf),   32'd0);

        // Push while full and not popping
        cycle(1'b1, 1'b0, 8'hEE);
        chk("ovf_set",   32'(ovf),   32'd1);
        chk("ovf_count", 32'(count), 32'd16);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            pop_chk("drain_out", 8'(8'h10 + i), 1'b0, 8'h00);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_udf",   32'(udf),   32'd0);

        // Pop while empty
        cycle(1'b0, 1'b1, 8'h00);
        chk("udf_set",   32'(udf),   32'd1);
        chk("udf_count", 32'(count), 32'd0);
`ifndef RAM_FIFO_FWFT_EN
        chk("udf_out_hold", 32'(out), 32'h1F);
`endif

        // Asynchronous reset mid-run at count 5
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'(8'h30 + i));
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ovf",   32'(ovf),   32'd0);
        chk("arst_udf",   32'(udf),   32'd0);
`ifndef RAM_FIFO_FWFT_EN
        chk("arst_out",   32'(out),   32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Wrap: push 12, pop 12, push 8, pop 8 (pointers cross 15->0)
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
        chk("wrap_count12", 32'(count), 32'd12);
        for (int i = 0; i < 12; i++) pop_chk("wrap_out_a", 8'(8'h20 + i), 1'b0, 8'h00);
        for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, 8'(8'h40 + i));
        chk("wrap_count8", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++)  pop_chk("wrap_out_b", 8'(8'h40 + i), 1'b0, 8'h00);
        chk("wrap_count0", 32'(count), 32'd0);
        chk("wrap_empty",  32'(empty), 32'd1);

        // Simultaneous push/pop at full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        chk("sf_full", 32'(full), 32'd1);
        pop_chk("sf_out0", 8'h60, 1'b1, 8'hAA);
        chk("sf_count", 32'(count), 32'd16);
        chk("sf_ovf",   32'(ovf),   32'd0);
        for (int i = 1; i < 16; i++) pop_chk("sf_out", 8'(8'h60 + i), 1'b0, 8'h00);
        pop_chk("sf_aa", 8'hAA, 1'b0, 8'h00);
        chk("sf_empty", 32'(empty), 32'd1);

        // Simultaneous push/pop at empty
        chk("se_udf_pre", 32'(udf), 32'd0);
        cycle(1'b1, 1'b1, 8'h55);
        chk("se_count", 32'(count), 32'd1);
        chk("se_udf",   32'(udf),   32'd1);
`ifndef RAM_FIFO_FWFT_EN
        chk("se_out_hold", 32'(out), 32'hAA);
`endif
        pop_chk("se_out", 8'h55, 1'b0, 8'h00);
        chk("se_count0", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
